// File: rtl/core_fetch_queue_if.sv
// Fetch-queue bundle: run control, per-lane instruction read ports, and the
// decode-facing instruction window. master = fetch queue, slave = environment.
interface core_fetch_queue_if #(
  parameter int FETCH_W = 2,
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
);
  localparam int OC_W = $clog2(FETCH_W + 1);

  logic                       exec;
  logic                       halt;
  logic                       pc_wen;
  logic [PC_W-1:0]            pc;
  logic                       redirect;
  logic [PC_W-1:0]            redirect_pc;
  logic [FETCH_W-1:0]         mem_val;
  logic [FETCH_W*PC_W-1:0]    mem_addr;
  logic [FETCH_W-1:0]         mem_rdy;
  logic [FETCH_W*INSTR_W-1:0] mem_rdata;
  logic [OC_W-1:0]            out_cnt;
  logic [FETCH_W*INSTR_W-1:0] out_instr;
  logic [FETCH_W*PC_W-1:0]    out_pc;
  logic [OC_W-1:0]            consume;
  logic [PC_W-1:0]            fetch_pc;
  logic                       idle;

  modport master (
    input  exec, halt, pc_wen, pc, redirect, redirect_pc,
    input  mem_rdy, mem_rdata, consume,
    output mem_val, mem_addr, out_cnt, out_instr, out_pc, fetch_pc, idle
  );

  modport slave (
    output exec, halt, pc_wen, pc, redirect, redirect_pc,
    output mem_rdy, mem_rdata, consume,
    input  mem_val, mem_addr, out_cnt, out_instr, out_pc, fetch_pc, idle
  );
endinterface

// File: rtl/core_fetch_queue.sv
// Fetch front end: FETCH_W-lane read groups into a QDEPTH queue; lane accept -> visible next cycle.
// New groups stall while fewer than FETCH_W slots are free; each lane holds its request until accepted.
module core_fetch_queue #(
  parameter int              FETCH_W  = 2,
  parameter int              QDEPTH   = 8,
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = 'h10
) (
  input logic                clk,
  input logic                rst,
  core_fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int OC_W  = $clog2(FETCH_W + 1);

  logic [PC_W-1:0]    fetch_pc;
  logic               active;
  logic [FETCH_W-1:0] done;
  logic [INSTR_W-1:0] lane_buf [FETCH_W];
  logic [INSTR_W-1:0] q_instr  [QDEPTH];
  logic [PC_W-1:0]    q_pc     [QDEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  logic               flush;
  logic               room;
  logic               start;
  logic               grp;
  logic               complete;
  logic [FETCH_W-1:0] val;
  logic [FETCH_W-1:0] acc;
  logic [INSTR_W-1:0] lane_word [FETCH_W];

  always_comb begin
    flush    = bus.pc_wen | bus.redirect;
    room     = count <= CNT_W'(QDEPTH - FETCH_W);
    start    = ~active & bus.exec & ~bus.halt & ~flush & room;
    grp      = active | start;
    val      = (grp && !rst) ? ~done : '0;
    acc      = val & bus.mem_rdy;
    // Lanes accepted this very cycle count as done for completion.
    complete = grp & ~rst & ~flush & (&(done | acc));
    for (int k = 0; k < FETCH_W; k++) begin
      lane_word[k] = acc[k] ? bus.mem_rdata[k*INSTR_W +: INSTR_W] : lane_buf[k];
    end
  end

  always_comb begin
    bus.mem_val   = val;
    bus.mem_addr  = '0;
    bus.out_instr = '0;
    bus.out_pc    = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      bus.mem_addr[k*PC_W +: PC_W]     = fetch_pc + PC_W'(k);
      bus.out_instr[k*INSTR_W +: INSTR_W] = q_instr[head + PTR_W'(k)];
      bus.out_pc[k*PC_W +: PC_W]       = q_pc[head + PTR_W'(k)];
    end
    if (rst)
      bus.out_cnt = '0;
    else if (count >= CNT_W'(FETCH_W))
      bus.out_cnt = OC_W'(FETCH_W);
    else
      bus.out_cnt = OC_W'(count);
    bus.fetch_pc = fetch_pc;
    bus.idle     = rst | (~active & (count == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      active   <= 1'b0;
      done     <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (flush) begin
      fetch_pc <= bus.pc_wen ? bus.pc : bus.redirect_pc;
      active   <= 1'b0;
      done     <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      head  <= head + PTR_W'(bus.consume);
      count <= count + (complete ? CNT_W'(FETCH_W) : CNT_W'(0)) - CNT_W'(bus.consume);
      if (complete) begin
        tail     <= tail + PTR_W'(FETCH_W);
        fetch_pc <= fetch_pc + PC_W'(FETCH_W);
        active   <= 1'b0;
        done     <= '0;
      end else if (grp) begin
        active <= 1'b1;
        done   <= done | acc;
      end
    end
  end

  // Storage carries no reset; validity is tracked by count/done alone.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_W; k++) begin
      if (acc[k])
        lane_buf[k] <= bus.mem_rdata[k*INSTR_W +: INSTR_W];
      if (complete) begin
        q_instr[tail + PTR_W'(k)] <= lane_word[k];
        q_pc[tail + PTR_W'(k)]    <= fetch_pc + PC_W'(k);
      end
    end
  end

  a_consume_legal: assert property (@(posedge clk) disable iff (rst || flush)
    bus.consume <= bus.out_cnt);
endmodule

// File: tb/tb_core_fetch_queue.sv
// Randomized bench for core_fetch_queue against a queue-based reference model.
module tb_core_fetch_queue;
  localparam int FW = 2;
  localparam int QD = 8;
  localparam logic [7:0] RST_PC = 8'h10;
  localparam int NCYC = 4000;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  core_fetch_queue_if #(.FETCH_W(FW), .PC_W(8), .INSTR_W(16)) bus ();

  core_fetch_queue #(
    .FETCH_W(FW), .QDEPTH(QD), .PC_W(8), .INSTR_W(16), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: fetch PC, in-flight group lanes, and a plain queue of entries.
  logic [7:0]    m_fpc;
  bit            m_active;
  bit [FW-1:0]   m_done;
  logic [15:0]   m_data [FW];
  ent_t          mq [$];

  initial begin
    bit          e_flush, e_room, e_start, e_grp, e_idle;
    bit [FW-1:0] e_val;
    int          e_cnt;
    ent_t        e;

    rst = 1'b1;
    bus.exec = 0; bus.halt = 0; bus.pc_wen = 0; bus.pc = '0;
    bus.redirect = 0; bus.redirect_pc = '0; bus.mem_rdy = '0;
    bus.mem_rdata = '0; bus.consume = '0;
    m_fpc = RST_PC; m_active = 0; m_done = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      rst = (cyc < 2) || ($urandom_range(0, 249) == 0);
      bus.mem_rdata = {16'($urandom), 16'($urandom)};
      if (cyc < 30) begin
        // Free-running fill: everything accepted, nothing consumed.
        bus.exec = 1; bus.halt = 0; bus.pc_wen = 0; bus.redirect = 0;
        bus.mem_rdy = '1;
      end else begin
        bus.exec     = ($urandom_range(0, 3) != 0);
        bus.halt     = ($urandom_range(0, 5) == 0);
        bus.pc_wen   = ($urandom_range(0, 59) == 0) || (cyc == 30);
        bus.pc       = ($urandom_range(0, 1) == 1 || cyc == 30) ?
                       8'($urandom_range(8'hFC, 8'hFF)) : 8'($urandom);
        bus.redirect = ($urandom_range(0, 39) == 0);
        bus.redirect_pc = 8'($urandom);
        for (int k = 0; k < FW; k++) bus.mem_rdy[k] = ($urandom_range(0, 2) != 0);
      end

      e_cnt   = rst ? 0 : ((mq.size() < FW) ? mq.size() : FW);
      bus.consume = (cyc < 30) ? '0 : 2'($urandom_range(0, e_cnt));
      e_flush = bus.pc_wen || bus.redirect;
      e_room  = (QD - mq.size()) >= FW;
      e_start = !m_active && bus.exec && !bus.halt && !e_flush && e_room;
      e_grp   = m_active || e_start;
      e_val   = (!rst && e_grp) ? ~m_done : '0;
      e_idle  = rst || (!m_active && mq.size() == 0);

      #1;
      if (cyc > 0) begin
        check_eq("mem_val", 64'(bus.mem_val), 64'(e_val));
        for (int k = 0; k < FW; k++)
          if (e_val[k]) check_eq("mem_addr", 64'(bus.mem_addr[k*8 +: 8]), 64'(8'(m_fpc + 8'(k))));
        check_eq("out_cnt", 64'(bus.out_cnt), 64'(e_cnt));
        for (int k = 0; k < e_cnt; k++) begin
          check_eq("out_pc", 64'(bus.out_pc[k*8 +: 8]), 64'(mq[k].pc));
          check_eq("out_instr", 64'(bus.out_instr[k*16 +: 16]), 64'(mq[k].instr));
        end
        check_eq("fetch_pc", 64'(bus.fetch_pc), 64'(m_fpc));
        check_eq("idle", 64'(bus.idle), 64'(e_idle));
      end

      @(posedge clk);
      if (rst) begin
        m_fpc = RST_PC; m_active = 0; m_done = '0; mq.delete();
      end else if (e_flush) begin
        m_fpc = bus.pc_wen ? bus.pc : bus.redirect_pc;
        m_active = 0; m_done = '0; mq.delete();
      end else begin
        for (int k = 0; k < FW; k++)
          if (e_val[k] && bus.mem_rdy[k]) begin
            m_data[k] = bus.mem_rdata[k*16 +: 16];
            m_done[k] = 1'b1;
          end
        for (int i = 0; i < int'(bus.consume); i++) void'(mq.pop_front());
        if (e_grp && (&m_done)) begin
          for (int k = 0; k < FW; k++) begin
            e.pc    = m_fpc + 8'(k);
            e.instr = m_data[k];
            mq.push_back(e);
          end
          m_fpc    = m_fpc + 8'(FW);
          m_done   = '0;
          m_active = 0;
        end else if (e_grp) begin
          m_active = 1;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/core_fetch_queue.md
Name: core_fetch_queue

Overview:
Parametrised instruction-fetch front end for the TOY core. Issues FETCH_W parallel reads per fetch group on the instruction read ports and buffers the fetched words with their PCs in a QDEPTH-entry queue. Presents up to FETCH_W in-order instructions per cycle to the decode/execute stage. Handles redirect (jump), manual PC write, halt and flush, decoupling memory latency from issue.

Parameters:
FETCH_W, 2, lanes per fetch group and max instructions presented per cycle (1..4)
QDEPTH, 8, queue entries; power of 2, >= 2*FETCH_W
PC_W, 8, PC/address width
INSTR_W, 16, instruction width
RESET_PC, 8'h10, fetch PC after reset

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
exec_i  in  1  allow new fetch groups to start
halt_i  in  1  block new fetch groups
pc_wen_i  in  1  manual PC write, flushes
pc_i  in  PC_W  manual PC value
redirect_i  in  1  taken jump from decode/execute, flushes
redirect_pc_i  in  PC_W  jump target
mem_val_o  out  FETCH_W  per-lane read request
mem_addr_o  out  FETCH_W*PC_W  per-lane address, lane k = group_pc+k
mem_rdy_i  in  FETCH_W  per-lane accept; rdata valid same cycle
mem_rdata_i  in  FETCH_W*INSTR_W  per-lane read data
out_cnt_o  out  $clog2(FETCH_W+1)  valid instructions presented = min(count, FETCH_W)
out_instr_o  out  FETCH_W*INSTR_W  slot k = queue entry head+k
out_pc_o  out  FETCH_W*PC_W  PC of slot k
consume_i  in  $clog2(FETCH_W+1)  instructions taken this cycle, <= out_cnt_o
fetch_pc_o  out  PC_W  next group PC
idle_o  out  1  no active group and queue empty

Behaviour:
- Reset: fetch_pc=RESET_PC, queue empty (head=tail=count=0), group inactive, lane-done flags 0. While rst_i is high: mem_val_o=0, out_cnt_o=0, idle_o=1. A reset asserted mid-group drops the group and any data returned in that cycle.
- Group start: when inactive, exec_i=1, halt_i=0, no flush, and QDEPTH-count >= FETCH_W (registered count only, no consume bypass). The group becomes active in the same cycle and mem_val_o asserts for all lanes combinationally.
- Active group:
  - Lane k holds mem_val_o[k]=1 and a stable address until mem_rdy_i[k]=1.
  - On accept, rdata is latched into the lane buffer, done[k] is set, and val drops for that lane.
  - Once started, the group ignores exec_i and halt_i.
- Group completion: at the edge where all lanes are done (including lanes accepted that cycle), all FETCH_W words are written to tail..tail+FETCH_W-1 in lane order with pc=group_pc+k. Then tail advances by FETCH_W, fetch_pc advances by FETCH_W, and done flags clear. A new group may start in the next cycle.
- Latency: lanes accepted in cycle N appear at the output (out_cnt_o>0) in cycle N+1.
- Arithmetic:
  - PC and lane addresses wrap mod 2^PC_W (8'hFF+1=8'h00).
  - head/tail wrap mod QDEPTH.
  - count_next = count + (FETCH_W if complete) - consume_i. Enqueue and consume in the same cycle are legal.
- Consume: head advances by consume_i. If consume_i > out_cnt_o, the input is illegal; the block asserts an error and does not guarantee behaviour.
- Flush (pc_wen_i or redirect_i):
  - Queue emptied and group deactivated.
  - Data accepted in the flush cycle is discarded.
  - fetch_pc is loaded with pc_i or redirect_pc_i.
  - No group starts in the flush cycle.
  - consume_i in the flush cycle is ignored.
- Priority: rst_i > pc_wen_i > redirect_i > group completion/start.
- Halt: halt_i suppresses group start only. An in-flight group completes and is enqueued, and the queue still drains.
- Full: with QDEPTH-count < FETCH_W, no group starts and mem_val_o=0.
- idle_o = ~active & (count==0).

Test Plan:
- Reset, FETCH_W=2, QDEPTH=8, rdy always 1, exec_i=1:
  - Cycle 1: addr 0x10/0x11 requested.
  - Cycle 2: out_cnt_o=2 with pc 0x10/0x11 and matching rdata.
  - fetch_pc_o=0x12.
- Lane 1 rdy delayed 3 cycles:
  - mem_val_o[0] drops after the first cycle while lane 1 holds addr 0x11 stable.
  - Enqueue occurs the cycle after lane 1 accepts, in order.
- consume_i=0 with rdy=1:
  - Groups at 0x10, 0x12, 0x14, 0x16 fill the queue (count=8).
  - mem_val_o=0 thereafter.
  - consume_i=2 for one cycle allows the group at 0x18 to start on the next cycle.
- redirect_i=1 with redirect_pc_i=0x40 while the queue holds 4 entries and a group is half-done:
  - Next cycle out_cnt_o=0.
  - First new request addr is 0x40/0x41; the stale lane data is never presented.
- pc_wen_i=1 with pc_i=0xFF:
  - Group requests 0xFF and 0x00.
  - Presented PCs are 0xFF, 0x00; fetch_pc_o=0x01.
- halt_i=1 asserted in the cycle after a group starts, with lanes stalled:
  - The group completes and is enqueued.
  - No further mem_val_o; idle_o=1 after the entries are consumed.
- rst_i=1 mid-group:
  - mem_val_o=0 and out_cnt_o=0.
  - Fetch restarts at 0x10 after deassert.
